alu_arbiter: RTL and testbench

Shares one combinational ALU among up to `N_REQ` requesters, such as the LCD input path, a test sequencer or a future CPU datapath. It uses round-robin arbitration with valid/ready handshakes on both the request side and the response side. Accepted operands are held on registered ALU inputs, and the result is captured and returned only to the requester that issued the operation. The block sits between the requesters and the `Alu` instance and contains no arithmetic of its own.

---
 rtl/alu_arbiter_if.sv | 24 ++
 rtl/alu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the shared-ALU arbiter.
// Operand fields are packed per requester: control [4i+3:4i], sources [32i+31:32i].
interface alu_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [4*N_REQ-1:0]    req_control;
    logic [32*N_REQ-1:0]   req_src1;
    logic [32*N_REQ-1:0]   req_src2;
    logic [N_REQ-1:0]      resp_valid;
    logic [N_REQ-1:0]      resp_ready;
    logic [31:0]           resp_result;

    modport master (
        output req_valid, req_control, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_control, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ requesters.
// Operands are registered toward the ALU; the result goes back only to the issuer.
module alu_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic [3:0]   alu_control,
    output logic [31:0]  alu_src1,
    output logic [31:0]  alu_src2,
    input  logic [31:0]  alu_result,
    output logic         busy,
    output logic [2:0]   grant_id,
    output logic [31:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              execPhase_q, execPhase_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        grant_q, grant_d;
    logic [3:0]        aluControl_q, aluControl_d;
    logic [31:0]       aluSrc1_q, aluSrc1_d;
    logic [31:0]       aluSrc2_q, aluSrc2_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       opCount_q, opCount_d;
    logic [N_REQ-1:0]  respValid_q, respValid_d;

    logic [7:0]        validPad;
    logic [7:0]        respReadyPad;
    logic              found;
    logic [2:0]        winner;
    logic [3:0]        cand;
    logic [3:0]        selControl;
    logic [31:0]       selSrc1;
    logic [31:0]       selSrc2;

    always_comb begin
        validPad = '0;
        validPad[N_REQ-1:0] = bus.req_valid;
        respReadyPad = '0;
        respReadyPad[N_REQ-1:0] = bus.resp_ready;
    end

    // Search starts just after the previous winner and wraps modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_q} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!found && validPad[cand[2:0]]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
    end

    always_comb begin
        selControl = '0;
        selSrc1    = '0;
        selSrc2    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == 3'(i)) begin
                selControl = bus.req_control[4*i +: 4];
                selSrc1    = bus.req_src1[32*i +: 32];
                selSrc2    = bus.req_src2[32*i +: 32];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_ready[i] = (state_q == IDLE) && found && (winner == 3'(i));
        end
    end

    // EXEC spends one cycle letting the registered operands settle through the ALU,
    // then captures the result on its second cycle.
    always_comb begin
        state_d      = state_q;
        execPhase_d  = execPhase_q;
        last_d       = last_q;
        grant_d      = grant_q;
        aluControl_d = aluControl_q;
        aluSrc1_d    = aluSrc1_q;
        aluSrc2_d    = aluSrc2_q;
        result_d     = result_q;
        opCount_d    = opCount_q;
        respValid_d  = respValid_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    aluControl_d = selControl;
                    aluSrc1_d    = selSrc1;
                    aluSrc2_d    = selSrc2;
                    grant_d      = winner;
                    last_d       = winner;
                    execPhase_d  = 1'b0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (!execPhase_q) begin
                    execPhase_d = 1'b1;
                end else begin
                    execPhase_d = 1'b0;
                    result_d    = alu_result;
                    for (int i = 0; i < N_REQ; i++) begin
                        respValid_d[i] = (grant_q == 3'(i));
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (respReadyPad[grant_q]) begin
                    respValid_d = '0;
                    opCount_d   = opCount_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight operation and points arbitration at requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            execPhase_q  <= 1'b0;
            last_q       <= 3'(N_REQ - 1);
            grant_q      <= '0;
            aluControl_q <= '0;
            aluSrc1_q    <= '0;
            aluSrc2_q    <= '0;
            result_q     <= '0;
            opCount_q    <= '0;
            respValid_q  <= '0;
        end else begin
            state_q      <= state_d;
            execPhase_q  <= execPhase_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            aluControl_q <= aluControl_d;
            aluSrc1_q    <= aluSrc1_d;
            aluSrc2_q    <= aluSrc2_d;
            result_q     <= result_d;
            opCount_q    <= opCount_d;
            respValid_q  <= respValid_d;
        end
    end

    assign bus.resp_valid  = respValid_q;
    assign bus.resp_result = result_q;
    assign alu_control     = aluControl_q;
    assign alu_src1        = aluSrc1_q;
    assign alu_src2        = aluSrc2_q;
    assign busy            = (state_q != IDLE);
    assign grant_id        = grant_q;
    assign op_count        = opCount_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle model predicts grants and results,
// expected responses are queued at acceptance and compared while the DUT responds.
module tb_alu_arbiter;

    localparam int NR = 4;
    localparam int M_IDLE  = 0;
    localparam int M_EXEC0 = 1;
    localparam int M_EXEC1 = 2;
    localparam int M_RESP  = 3;

    typedef struct {
        logic [2:0]  id;
        logic [3:0]  ctrl;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] res;
    } expItem_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic        busy;
    logic [2:0]  grant_id;
    logic [31:0] op_count;

    alu_arbiter_if #(.N_REQ(NR)) bus ();

    alu_arbiter #(.N_REQ(NR)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .alu_control (alu_control),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_result  (alu_result),
        .busy        (busy),
        .grant_id    (grant_id),
        .op_count    (op_count)
    );

    assign alu_result = alu_src1 + alu_src2;

    always #50 clk = ~clk;

    int          checkCount = 0;
    int          errorCount = 0;
    bit          monitorOn  = 1'b0;
    bit          forceWrap  = 1'b0;
    logic [NR-1:0] acceptNow = '0;

    int          mState  = M_IDLE;
    int          mLast   = NR - 1;
    int          mGrant  = 0;
    logic [31:0] mCount  = '0;
    logic [31:0] mResult = '0;
    expItem_t    mLastItem = '{id: 3'd0, ctrl: 4'd0, s1: 32'd0, s2: 32'd0, res: 32'd0};
    expItem_t    scoreQ[$];
    int          grantLog[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Model of the arbiter, evaluated between edges: check current outputs, then step.
    always @(negedge clk) begin
        logic [NR-1:0] expReady;
        logic [NR-1:0] expRespValid;
        int            w;
        expItem_t      it;

        expReady = '0;
        w = -1;
        if (mState == M_IDLE) begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (mLast + k) % NR;
                if (w < 0 && bus.req_valid[idx]) w = idx;
            end
            if (w >= 0) expReady[w] = 1'b1;
        end
        expRespValid = '0;
        if (mState == M_RESP) expRespValid[mGrant] = 1'b1;

        if (monitorOn) begin
            checkOutput("req_ready",   32'(bus.req_ready),   32'(expReady));
            checkOutput("resp_valid",  32'(bus.resp_valid),  32'(expRespValid));
            checkOutput("resp_result", bus.resp_result,      mResult);
            checkOutput("busy",        32'(busy),            32'(mState != M_IDLE));
            checkOutput("grant_id",    32'(grant_id),        32'(mGrant));
            checkOutput("op_count",    op_count,             mCount);
            checkOutput("alu_control", 32'(alu_control),     32'(mLastItem.ctrl));
            checkOutput("alu_src1",    alu_src1,             mLastItem.s1);
            checkOutput("alu_src2",    alu_src2,             mLastItem.s2);
        end

        acceptNow = '0;
        if (reset) begin
            mState    = M_IDLE;
            mLast     = NR - 1;
            mGrant    = 0;
            mCount    = '0;
            mResult   = '0;
            mLastItem = '{id: 3'd0, ctrl: 4'd0, s1: 32'd0, s2: 32'd0, res: 32'd0};
            scoreQ.delete();
        end else begin
            case (mState)
                M_IDLE: begin
                    if (w >= 0) begin
                        it.id   = 3'(w);
                        it.ctrl = bus.req_control[4*w +: 4];
                        it.s1   = bus.req_src1[32*w +: 32];
                        it.s2   = bus.req_src2[32*w +: 32];
                        it.res  = it.s1 + it.s2;
                        scoreQ.push_back(it);
                        grantLog.push_back(w);
                        mLastItem = it;
                        acceptNow[w] = 1'b1;
                        mLast  = w;
                        mGrant = w;
                        mState = M_EXEC0;
                    end
                end
                M_EXEC0: mState = M_EXEC1;
                M_EXEC1: begin
                    mResult = scoreQ[0].res;
                    mState  = M_RESP;
                end
                default: begin
                    if (bus.resp_ready[mGrant]) begin
                        it = scoreQ.pop_front();
                        checkOutput("sb_result", bus.resp_result, it.res);
                        mCount = mCount + 32'd1;
                        mState = M_IDLE;
                    end
                end
            endcase
        end
        if (forceWrap) mCount = 32'hFFFF_FFFF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~acceptNow;
    endtask

    task automatic applyStimulus(input int id, input logic [3:0] ctrl, input logic [31:0] s1, input logic [31:0] s2);
        bus.req_control[4*id +: 4] = ctrl;
        bus.req_src1[32*id +: 32]  = s1;
        bus.req_src2[32*id +: 32]  = s2;
        bus.req_valid[id]          = 1'b1;
    endtask

    task automatic drain(input string tag, input int maxCycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxCycles && !done; c++) begin
            tick();
            if (mState == M_IDLE && scoreQ.size() == 0 && bus.req_valid == '0) done = 1'b1;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic waitResp(input string tag, input int maxCycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxCycles && !done; c++) begin
            tick();
            if (mState == M_RESP) done = 1'b1;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},       32'(busy),            32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid),  32'd0);
        checkOutput({tag, "_resp_res"},   bus.resp_result,      32'd0);
        checkOutput({tag, "_grant"},      32'(grant_id),        32'd0);
        checkOutput({tag, "_alu_ctrl"},   32'(alu_control),     32'd0);
        checkOutput({tag, "_alu_src1"},   alu_src1,             32'd0);
        checkOutput({tag, "_alu_src2"},   alu_src2,             32'd0);
        checkOutput({tag, "_op_count"},   op_count,             32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int logBase;
        reset           = 1'b1;
        bus.req_valid   = '0;
        bus.req_control = '0;
        bus.req_src1    = '0;
        bus.req_src2    = '0;
        bus.resp_ready  = '1;
        repeat (3) tick();
        reset = 1'b0;
        checkResetValues("init");
        monitorOn = 1'b1;

        $display("[TB] single request on requester 0");
        applyStimulus(0, 4'h2, 32'd5, 32'd3);
        #1;
        checkOutput("s1_ready_same_cycle", 32'(bus.req_ready), 32'h1);
        drain("s1_drain", 40);
        checkOutput("s1_result", bus.resp_result, 32'd8);
        checkOutput("s1_alu_ctrl", 32'(alu_control), 32'h2);
        checkOutput("s1_op_count", op_count, 32'd1);

        $display("[TB] all four requesters from reset");
        pulseReset();
        grantLog.delete();
        for (int i = 0; i < NR; i++) applyStimulus(i, 4'(i), 32'(100 * i + 7), 32'(3 * i));
        drain("s2_drain", 100);
        checkOutput("s2_grants", 32'(grantLog.size()), 32'd4);
        for (int i = 0; i < NR && i < grantLog.size(); i++) checkOutput("s2_order", 32'(grantLog[i]), 32'(i));
        checkOutput("s2_op_count", op_count, 32'd4);

        $display("[TB] round-robin rotation");
        applyStimulus(2, 4'h1, 32'd20, 32'd22);
        drain("s3_drain_a", 40);
        grantLog.delete();
        applyStimulus(0, 4'h3, 32'd1, 32'd1);
        applyStimulus(3, 4'h4, 32'd9, 32'd9);
        drain("s3_drain_b", 60);
        checkOutput("s3_grants", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() == 2) begin
            checkOutput("s3_first", 32'(grantLog[0]), 32'd3);
            checkOutput("s3_second", 32'(grantLog[1]), 32'd0);
        end

        $display("[TB] response backpressure");
        bus.resp_ready = 4'b1101;
        applyStimulus(1, 4'h5, 32'h1234_0000, 32'h0000_5678);
        waitResp("s4_reach_resp", 20);
        applyStimulus(2, 4'h6, 32'd40, 32'd2);
        logBase = grantLog.size();
        repeat (5) tick();
        checkOutput("s4_held_result", bus.resp_result, 32'h1234_5678);
        checkOutput("s4_held_valid", 32'(bus.resp_valid), 32'h2);
        checkOutput("s4_req2_blocked", 32'(grantLog.size()), 32'(logBase));
        bus.resp_ready = '1;
        tick();
        tick();
        checkOutput("s4_req2_accepted", 32'(grantLog.size()), 32'(logBase + 1));
        if (grantLog.size() > logBase) checkOutput("s4_req2_id", 32'(grantLog[logBase]), 32'd2);
        drain("s4_drain", 40);

        $display("[TB] reset during EXEC");
        applyStimulus(2, 4'h7, 32'd77, 32'd11);
        tick();
        checkOutput("s5a_in_exec", 32'(busy), 32'd1);
        pulseReset();
        checkResetValues("s5a");
        grantLog.delete();
        applyStimulus(2, 4'h1, 32'd2, 32'd2);
        applyStimulus(0, 4'h1, 32'd3, 32'd3);
        drain("s5a_drain", 60);
        if (grantLog.size() > 0) checkOutput("s5a_first_grant", 32'(grantLog[0]), 32'd0);

        $display("[TB] reset during RESP");
        applyStimulus(1, 4'h2, 32'd50, 32'd50);
        waitResp("s5b_reach_resp", 20);
        pulseReset();
        checkResetValues("s5b");
        tick();
        checkOutput("s5b_no_pulse", 32'(bus.resp_valid), 32'd0);
        grantLog.delete();
        applyStimulus(3, 4'h1, 32'd4, 32'd4);
        applyStimulus(0, 4'h1, 32'd6, 32'd6);
        drain("s5b_drain", 60);
        if (grantLog.size() > 0) checkOutput("s5b_first_grant", 32'(grantLog[0]), 32'd0);

        $display("[TB] op_count wrap");
        tick();
        force dut.opCount_d = 32'hFFFF_FFFF;
        forceWrap = 1'b1;
        tick();
        release dut.opCount_d;
        forceWrap = 1'b0;
        checkOutput("s6_preload", op_count, 32'hFFFF_FFFF);
        applyStimulus(1, 4'h0, 32'hFFFF_FFF0, 32'h0000_0020);
        drain("s6_drain", 40);
        checkOutput("s6_wrapped", op_count, 32'd0);
        checkOutput("s6_result", bus.resp_result, 32'h0000_0010);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
